// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and sizing helper for the PISO serializer
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_t;
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width);
  endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out serializer with frame markers and zero-gap streaming
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic clk,
  input logic reset,
  input logic [DATA_WIDTH-1:0] parallel_in,
  input logic load_valid,
  output logic load_ready,
  output logic serial_out,
  output logic serial_valid,
  output logic frame_start,
  output logic done,
  output logic busy
);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(DATA_WIDTH - 1);
  piso_state_t state, state_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n, shifted;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic fire, last;
  always_comb begin
    load_ready = !reset && (state == IDLE || (state == SHIFT && bit_cnt == '0));
    fire = load_valid && load_ready;
    last = state == SHIFT && bit_cnt == '0;
    shifted = MSB_FIRST ? {sreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, sreg[DATA_WIDTH-1:1]};
    state_n = fire ? SHIFT : last ? IDLE : state;
    sreg_n = fire ? parallel_in : state == SHIFT ? shifted : sreg;
    cnt_n = fire ? CNT_TOP : (state == SHIFT && !last) ? bit_cnt - CW'(1) : bit_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      serial_out <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      frame_start <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      bit_cnt <= cnt_n;
      serial_valid <= state_n == SHIFT;
      serial_out <= state_n == SHIFT ? (MSB_FIRST ? sreg_n[DATA_WIDTH-1] : sreg_n[0]) : IDLE_LEVEL;
      frame_start <= fire;
      done <= state_n == SHIFT && cnt_n == '0;
    end
  end
  assign busy = serial_valid;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench driving MSB-first and LSB-first serializers with sipo loopback
module tb_piso_serializer;
  localparam int W = 16;
  typedef struct {
    int cyc;
    logic [W-1:0] word;
    int k;
  } ent_t;
  logic clk, reset, load_valid;
  logic [W-1:0] parallel_in;
  logic ready_m, out_m, valid_m, start_m, done_m, busy_m;
  logic ready_l, out_l, valid_l, start_l, done_l, busy_l;
  logic [W-1:0] sipo_m, sipo_l, sw, ew;
  logic armed, chk_sipo;
  int cyc, free_at, total, passes;
  ent_t q[$];
  ent_t e;
  piso_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(ready_m), .serial_out(out_m), .serial_valid(valid_m),
    .frame_start(start_m), .done(done_m), .busy(busy_m)
  );
  piso_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(ready_l), .serial_out(out_l), .serial_valid(valid_l),
    .frame_start(start_l), .done(done_l), .busy(busy_l)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (valid_m) sipo_m <= {sipo_m[W-2:0], out_m};
    if (valid_l) sipo_l <= {out_l, sipo_l[W-1:1]};
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
    logic er;
    load_valid = v;
    parallel_in = d;
    reset = r;
    #1;
    er = !r && cyc >= free_at;
    chk("load_ready_msb", ready_m, er);
    chk("load_ready_lsb", ready_l, er);
    acc = v && er;
    if (acc) begin
      for (int k = 0; k < W; k++) q.push_back('{cyc: cyc + 1 + k, word: d, k: k});
      free_at = cyc + W;
    end
    if (r) begin
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
      free_at = cyc + 1;
    end
    @(posedge clk);
    #1;
    if (r) armed = 1'b1;
  endtask
  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, acc);
  endtask
  task automatic send(input logic [W-1:0] d);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      step(1'b1, d, 1'b0, acc);
      n++;
    end
    chk("accept_in_time", acc, 1'b1);
  endtask
  always @(negedge clk) begin
    if (armed) begin
      if (chk_sipo) begin
        chk("loopback_msb", sipo_m, sw);
        chk("loopback_lsb", sipo_l, sw);
        chk_sipo = 1'b0;
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        ew = e.word;
        chk("valid_msb", valid_m, 1'b1);
        chk("valid_lsb", valid_l, 1'b1);
        chk("bit_msb", out_m, ew[W-1-e.k]);
        chk("bit_lsb", out_l, ew[e.k]);
        chk("start_msb", start_m, e.k == 0);
        chk("start_lsb", start_l, e.k == 0);
        chk("done_msb", done_m, e.k == W - 1);
        chk("done_lsb", done_l, e.k == W - 1);
        chk("busy", {busy_m, busy_l}, 2'b11);
        if (e.k == W - 1) begin
          chk_sipo = 1'b1;
          sw = e.word;
        end
      end else begin
        chk("idle_valid", {valid_m, valid_l, busy_m, busy_l}, 4'b0);
        chk("idle_out", {out_m, out_l}, 2'b0);
        chk("idle_marks", {start_m, done_m, start_l, done_l}, 4'b0);
      end
    end
  end
  initial begin
    logic acc;
    total = 0;
    passes = 0;
    free_at = 0;
    armed = 1'b0;
    chk_sipo = 1'b0;
    reset = 1'b1;
    load_valid = 1'b0;
    parallel_in = '0;
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    idle(5);
    send(16'hA5C3);
    idle(20);
    send(16'h0001);
    idle(20);
    send(16'hFFFF);
    send(16'h0000);
    idle(20);
    send(16'hBEEF);
    idle(5);
    step(1'b1, 16'hCAFE, 1'b1, acc);
    send(16'h1234);
    idle(20);
    send(16'hBEEF);
    idle(20);
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(20);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer. It sits directly upstream of the sipo shift register and drives its serial_in, one bit per clk. It accepts a DATA_WIDTH word through a valid/ready handshake and emits the word one bit per cycle with frame markers. Back-to-back words stream with no idle gap.

Parameters:
DATA_WIDTH, 16, word width in bits; legal range 2 or more.
MSB_FIRST, 1, 1 = bit DATA_WIDTH-1 goes out first; 0 = bit 0 goes out first.
IDLE_LEVEL, 0, level driven on serial_out when no bit is valid.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
parallel_in  input  DATA_WIDTH  word to serialize; sampled only on the handshake cycle.
load_valid  input  1  upstream has a word on parallel_in.
load_ready  output  1  serializer can accept a word this cycle.
serial_out  output  1  serial bit stream, connects to sipo serial_in.
serial_valid  output  1  serial_out carries a data bit this cycle.
frame_start  output  1  pulse with the first bit of each word.
done  output  1  pulse with the last bit of each word.
busy  output  1  a frame is in progress (equals serial_valid).

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk.
- Synchronous reset. While reset is high at an edge:
  - state <= IDLE, shift register <= 0, bit counter <= 0.
  - serial_out <= IDLE_LEVEL.
  - serial_valid, frame_start, done, busy <= 0.
  - load_ready = 0 for every cycle in which reset is high.
- State machine, states IDLE and SHIFT:
  - Handshake fires when load_valid && load_ready. parallel_in is captured only on that cycle.
  - load_ready = !reset && (state==IDLE || (state==SHIFT && bit_cnt==0)). It is derived from registered state only, with no combinational path from load_valid.
  - IDLE + handshake -> SHIFT; bit_cnt <= DATA_WIDTH-1.
  - IDLE without a handshake -> stays in IDLE; outputs remain idle.
  - SHIFT with bit_cnt>0 -> shift one position, bit_cnt decrements.
  - SHIFT with bit_cnt==0 (last bit) + handshake -> reload the new word, bit_cnt <= DATA_WIDTH-1, stay in SHIFT (zero-gap streaming).
  - SHIFT with bit_cnt==0 and no handshake -> IDLE.
- Latency and timing, for a handshake at cycle N:
  - serial_out and serial_valid are registered outputs.
  - The first bit appears in cycle N+1 with frame_start=1.
  - Bit k appears in cycle N+1+k.
  - The last bit appears in cycle N+DATA_WIDTH with done=1.
  - Throughput: one word every DATA_WIDTH cycles when streaming.
- Bit order:
  - MSB_FIRST=1: the shift register shifts left and serial_out = sreg[DATA_WIDTH-1].
  - MSB_FIRST=0: the shift register shifts right and serial_out = sreg[0].
  - The vacated bit position fills with 0.
- Idle cycles: serial_valid=0 and serial_out=IDLE_LEVEL.
- Counter: width $clog2(DATA_WIDTH). It never wraps below 0; reaching bit_cnt==0 while in SHIFT defines the last bit.
- Boundary conditions:
  - load_valid while busy with bit_cnt>0: load_ready=0, so the word is not taken; upstream must hold it.
  - load_valid and reset in the same cycle: reset wins; the word is dropped.
  - Reset mid-frame: the frame is aborted; no done pulse; outputs are idle from the next cycle.
  - parallel_in changes after the handshake: no effect on the frame in flight.
- frame_start and done are each high for exactly one cycle per word. For DATA_WIDTH>=2 they are never high in the same cycle.

Decomposition:
- Package piso_pkg:
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
  - Function cnt_width(DATA_WIDTH), returning $clog2.
- No sub-module. The shifter, counter and FSM stay in one module. The sipo is instantiated only in the bench.

Test Plan:
- Reset then idle: hold reset for 2 cycles, release, leave load_valid=0 for 5 cycles -> serial_valid=0, serial_out=0, load_ready=1 from the first cycle after release.
- Single word, MSB_FIRST=1: load 16'hA5C3 at cycle N -> bits 1010 0101 1100 0011 in cycles N+1..N+16; frame_start at N+1; done at N+16; load_ready=0 for N+1..N+15.
- LSB_FIRST (MSB_FIRST=0): load 16'h0001 -> bit 1 in cycle N+1, then 15 zeros; done at N+16.
- Back-to-back: 16'hFFFF with load_valid held high, followed by 16'h0000 -> 16 ones then 16 zeros in consecutive cycles; serial_valid never drops; done pulses at N+16 and N+32; frame_start at N+1 and N+17.
- Reset mid-frame: load 16'hBEEF, assert reset after 5 bits -> no done pulse; serial_valid=0 next cycle; the next load of 16'h1234 serializes cleanly.
- Loopback: drive sipo serial_in from serial_out (sipo shifts toward MSB, inserting at bit 0) and gate its clock enable with serial_valid; load 16'hBEEF -> sipo parallel_out == 16'hBEEF in the cycle after done.
